config_chain_loader: RTL

Sequencer that programs the serial configuration chain of the routing fabric (disjoint switch boxes and programmable muxes) from a word-wide stream. It serialises each word LSB-first onto `prog_in`, generates `prog_clk` and `prog_en`, and captures the bits shifted out on `prog_out` as a readback stream. It sits between the bitstream source (host/ROM interface) and the head of the `prog_in`/`prog_out` daisy chain.

---
 rtl/config_chain_loader.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/config_chain_loader.sv
// Serialises a word stream LSB-first onto the fabric configuration chain, generating
// prog_clk/prog_en and collecting the bits that fall out of the chain tail as readback words.
module config_chain_loader #(
  parameter int CHAIN_LEN = 24,
  parameter int DATA_W    = 8,
  parameter int DIV       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              prog_in,
  output logic              prog_clk,
  output logic              prog_en,
  input  logic              prog_out,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int CW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_W - 1);
  localparam logic [CW-1:0] LAST_CHAIN = CW'(CHAIN_LEN - 1);
  localparam logic [DW-1:0] LAST_PH    = DW'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SETUP = 3'd2,
    HIGH  = 3'd3,
    LOW   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]     chain_cnt_q, chain_cnt_d;
  logic [DW-1:0]     ph_cnt_q, ph_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] rb_shift_q, rb_shift_d;
  logic              in_ready_q, in_ready_d;
  logic              prog_in_q, prog_in_d;
  logic              prog_clk_q, prog_clk_d;
  logic              prog_en_q, prog_en_d;
  logic [DATA_W-1:0] rb_data_q, rb_data_d;
  logic              rb_valid_q, rb_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Handshake: a word transfers on a rising clk edge where in_valid and in_ready are both 1;
  // in_ready is only high in LOAD and the source holds in_data while in_valid waits.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    chain_cnt_d = chain_cnt_q;
    ph_cnt_d    = ph_cnt_q;
    shift_d     = shift_q;
    rb_shift_d  = rb_shift_q;
    rb_data_d   = rb_data_q;
    rb_valid_d  = 1'b0;
    prog_in_d   = prog_in_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = LOAD;
          bit_cnt_d   = '0;
          chain_cnt_d = '0;
          ph_cnt_d    = '0;
        end
      end
      LOAD: begin
        if (in_valid && in_ready_q) begin
          shift_d    = in_data;
          rb_shift_d = '0;
          bit_cnt_d  = '0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        // prog_out still shows the tail bit from before this bit's rising edge
        rb_shift_d[bit_cnt_q] = prog_out;
        if (bit_cnt_q == LAST_BIT || chain_cnt_q == LAST_CHAIN) begin
          rb_valid_d = 1'b1;
          rb_data_d  = rb_shift_d;
        end
        ph_cnt_d = '0;
        state_d  = HIGH;
      end
      HIGH: begin
        if (ph_cnt_q == LAST_PH) begin
          ph_cnt_d = '0;
          state_d  = LOW;
        end else begin
          ph_cnt_d = ph_cnt_q + DW'(1);
        end
      end
      LOW: begin
        if (ph_cnt_q != LAST_PH) begin
          ph_cnt_d = ph_cnt_q + DW'(1);
        end else if (chain_cnt_q == LAST_CHAIN) begin
          state_d = DONE;
        end else begin
          chain_cnt_d = chain_cnt_q + CW'(1);
          if (bit_cnt_q == LAST_BIT) begin
            state_d = LOAD;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            state_d   = SETUP;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == SETUP) begin
      prog_in_d = shift_d[bit_cnt_d];
    end

    // Outputs are registered copies of what the next state requires
    in_ready_d = (state_d == LOAD);
    prog_clk_d = (state_d == HIGH);
    prog_en_d  = (state_d inside {LOAD, SETUP, HIGH, LOW});
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      chain_cnt_q <= '0;
      ph_cnt_q    <= '0;
      shift_q     <= '0;
      rb_shift_q  <= '0;
      in_ready_q  <= 1'b0;
      prog_in_q   <= 1'b0;
      prog_clk_q  <= 1'b0;
      prog_en_q   <= 1'b0;
      rb_data_q   <= '0;
      rb_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      chain_cnt_q <= chain_cnt_d;
      ph_cnt_q    <= ph_cnt_d;
      shift_q     <= shift_d;
      rb_shift_q  <= rb_shift_d;
      in_ready_q  <= in_ready_d;
      prog_in_q   <= prog_in_d;
      prog_clk_q  <= prog_clk_d;
      prog_en_q   <= prog_en_d;
      rb_data_q   <= rb_data_d;
      rb_valid_q  <= rb_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign prog_in   = prog_in_q;
  assign prog_clk  = prog_clk_q;
  assign prog_en   = prog_en_q;
  assign rb_data   = rb_data_q;
  assign rb_valid  = rb_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
